// File: rtl/tlu_dut_responder.sv
// DUT-side TLU trigger handshake: synchronises the trigger line, answers with BUSY/TLU_CLOCK
// and deserialises the trigger number LSB first. Optional trigger-stuck timeout: TLU_DUT_RESP_TIMEOUT_EN.
module tlu_dut_responder #(
    parameter int TRIGGER_BITS   = 16,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        EN,
    input  logic [1:0]  MODE,
    input  logic [7:0]  CLK_HALF,
    input  logic [15:0] DEAD_TIME,
    input  logic        TLU_TRIGGER,
    output logic        TLU_BUSY,
    output logic        TLU_CLOCK,
    output logic [31:0] TRIGGER_ID,
    output logic        TRIGGER_ID_VALID,
    output logic [31:0] TRIGGER_COUNT,
    output logic        TIMEOUT_ERR
);

    typedef enum logic [2:0] {IDLE, WAIT_LOW, CLK_HI, CLK_LO, LATCH, DEAD} state_t;

    state_t                  state_q, state_d;
    logic                    sync1_q, sync2_q, prev_q;
    logic                    busy_q, busy_d;
    logic                    tclk_q, tclk_d;
    logic [31:0]             id_q, id_d;
    logic                    valid_q, valid_d;
    logic [31:0]             count_q, count_d;
    logic                    data_mode_q, data_mode_d;
    logic [7:0]              half_q, half_d;
    logic [15:0]             cnt_q, cnt_d;
    logic [5:0]              bit_q, bit_d;
    logic [TRIGGER_BITS-1:0] shift_q, shift_d;
    logic                    rise;

`ifdef TLU_DUT_RESP_TIMEOUT_EN
    logic [31:0]             to_q, to_d;
    logic                    err_q, err_d;
`else
    logic                    unused_timeout;
    assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

    // Only a fresh 0->1 transition of the synchronised line counts as a trigger.
    assign rise = sync2_q & ~prev_q;

    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        tclk_d      = tclk_q;
        id_d        = id_q;
        valid_d     = 1'b0;
        count_d     = count_q;
        data_mode_d = data_mode_q;
        half_d      = half_q;
        cnt_d       = cnt_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
`ifdef TLU_DUT_RESP_TIMEOUT_EN
        to_d        = to_q;
        err_d       = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (rise && EN) begin
                    if (MODE == 2'd1 || MODE == 2'd2) begin
                        busy_d      = 1'b1;
                        data_mode_d = (MODE == 2'd2);
                        half_d      = (CLK_HALF == 8'd0) ? 8'd1 : CLK_HALF;
`ifdef TLU_DUT_RESP_TIMEOUT_EN
                        to_d        = 32'd0;
`endif
                        state_d     = WAIT_LOW;
                    end else begin
                        id_d    = count_q;
                        valid_d = 1'b1;
                        count_d = count_q + 32'd1;
                    end
                end
            end
            WAIT_LOW: begin
                if (!sync2_q) begin
                    shift_d = '0;
                    bit_d   = 6'd0;
                    cnt_d   = 16'd0;
                    if (data_mode_q) begin
                        tclk_d  = 1'b1;
                        state_d = CLK_HI;
                    end else begin
                        state_d = LATCH;
                    end
                end
`ifdef TLU_DUT_RESP_TIMEOUT_EN
                else if (to_q == 32'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    cnt_d   = 16'd0;
                    state_d = DEAD;
                end else begin
                    to_d = to_q + 32'd1;
                end
`endif
            end
            CLK_HI: begin
                if (cnt_q == {8'd0, half_q - 8'd1}) begin
                    cnt_d   = 16'd0;
                    tclk_d  = 1'b0;
                    state_d = CLK_LO;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            CLK_LO: begin
                if (cnt_q == {8'd0, half_q - 8'd1}) begin
                    // Sample as late as possible to give the TLU the whole period to update.
                    cnt_d = 16'd0;
                    for (int i = 0; i < TRIGGER_BITS; i++) begin
                        if (bit_q == 6'(i)) shift_d[i] = sync2_q;
                    end
                    if (bit_q == 6'(TRIGGER_BITS - 1)) begin
                        state_d = LATCH;
                    end else begin
                        bit_d   = bit_q + 6'd1;
                        tclk_d  = 1'b1;
                        state_d = CLK_HI;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            LATCH: begin
                id_d    = 32'(shift_q);
                valid_d = 1'b1;
                count_d = count_q + 32'd1;
                cnt_d   = 16'd0;
                state_d = DEAD;
            end
            DEAD: begin
                if (cnt_q >= DEAD_TIME) begin
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            sync1_q     <= 1'b0;
            sync2_q     <= 1'b0;
            prev_q      <= 1'b0;
            busy_q      <= 1'b0;
            tclk_q      <= 1'b0;
            id_q        <= 32'd0;
            valid_q     <= 1'b0;
            count_q     <= 32'd0;
            data_mode_q <= 1'b0;
            half_q      <= 8'd1;
            cnt_q       <= 16'd0;
            bit_q       <= 6'd0;
            shift_q     <= '0;
`ifdef TLU_DUT_RESP_TIMEOUT_EN
            to_q        <= 32'd0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sync1_q     <= TLU_TRIGGER;
            sync2_q     <= sync1_q;
            prev_q      <= sync2_q;
            busy_q      <= busy_d;
            tclk_q      <= tclk_d;
            id_q        <= id_d;
            valid_q     <= valid_d;
            count_q     <= count_d;
            data_mode_q <= data_mode_d;
            half_q      <= half_d;
            cnt_q       <= cnt_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
`ifdef TLU_DUT_RESP_TIMEOUT_EN
            to_q        <= to_d;
            err_q       <= err_d;
`endif
        end
    end

    assign TLU_BUSY         = busy_q;
    assign TLU_CLOCK        = tclk_q;
    assign TRIGGER_ID       = id_q;
    assign TRIGGER_ID_VALID = valid_q;
    assign TRIGGER_COUNT    = count_q;
`ifdef TLU_DUT_RESP_TIMEOUT_EN
    assign TIMEOUT_ERR      = err_q;
`else
    assign TIMEOUT_ERR      = 1'b0;
`endif

endmodule

// File: doc/tlu_dut_responder.md
Name: tlu_dut_responder

Overview:
- DUT-side end of the TLU trigger handshake: receives the trigger line, drives BUSY and the trigger-ID clock back to the TLU, and deserialises the trigger number.
- Used as an on-board DUT emulator for loopback and self-test of the TLU master outputs, and as the reusable DUT interface in detector readout firmware.
- Single clock domain; the trigger input is asynchronous and synchronised internally.

Parameters:
- TRIGGER_BITS, 16, number of trigger-ID bits clocked out per handshake (1..32).
- TIMEOUT_CYCLES, 65535, trigger-deassert timeout in CLK cycles; used only with the optional feature.

Ports:
- CLK  in  1  block clock.
- RST  in  1  synchronous, active-high reset.
- EN  in  1  accept new triggers when high.
- MODE  in  2  0 = trigger only, 1 = handshake, 2 = data handshake, 3 = same as 0.
- CLK_HALF  in  8  TLU_CLOCK half period in CLK cycles; 0 is treated as 1.
- DEAD_TIME  in  16  extra BUSY hold after the transaction, in CLK cycles.
- TLU_TRIGGER  in  1  asynchronous trigger/data line from the TLU.
- TLU_BUSY  out  1  busy to the TLU, registered.
- TLU_CLOCK  out  1  trigger-ID clock to the TLU, registered.
- TRIGGER_ID  out  32  last received ID, zero-extended above TRIGGER_BITS.
- TRIGGER_ID_VALID  out  1  one-cycle strobe when TRIGGER_ID updates.
- TRIGGER_COUNT  out  32  completed transactions; wraps 0xFFFFFFFF -> 0.
- TIMEOUT_ERR  out  1  sticky trigger-stuck flag.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, synchroniser cleared. Reset mid-transaction aborts on the next edge: BUSY=0, CLOCK=0, no VALID strobe.
- Input path: 2-FF synchroniser followed by a registered edge detector.
  - TLU_TRIGGER rising at edge k is acted on at edge k+2.
  - TLU_BUSY is high after edge k+2.
- Only a 0->1 edge of the synchronised trigger starts a transaction. A level still high when returning to IDLE never retriggers.
- EN is sampled in IDLE only. Deasserting EN mid-transaction does not abort it.
- FSM states: IDLE, WAIT_LOW, CLK_HI, CLK_LO, LATCH, DEAD.
- IDLE: on a rising edge with EN=1:
  - MODE 0/3: pulse TRIGGER_ID_VALID with TRIGGER_ID = TRIGGER_COUNT (pre-increment), increment the count, stay in IDLE, BUSY stays 0.
  - MODE 1/2: set BUSY, go to WAIT_LOW.
- WAIT_LOW: wait for the synchronised trigger to be 0.
  - MODE 1: go to LATCH with ID 0.
  - MODE 2: clear the shift register and bit counter, go to CLK_HI.
- CLK_HI: TLU_CLOCK=1 for CLK_HALF cycles, then go to CLK_LO.
- CLK_LO: TLU_CLOCK=0 for CLK_HALF cycles.
  - In the last cycle of the low phase, sample the synchronised trigger into bit[n]. The first sample is bit 0 (LSB first).
  - n < TRIGGER_BITS-1: go to CLK_HI. Otherwise go to LATCH.
  - Timing constraint on the TLU side: TLU update delay + 2 sync cycles must be < 2*CLK_HALF.
- LATCH (1 cycle): TRIGGER_ID <= shift register, VALID=1, TRIGGER_COUNT+1, go to DEAD.
- DEAD: BUSY held for DEAD_TIME cycles, then BUSY=0 and go to IDLE. DEAD_TIME=0 releases BUSY on the edge after LATCH.
- Exactly TRIGGER_BITS TLU_CLOCK pulses per MODE 2 transaction.
- A new trigger edge during WAIT_LOW..DEAD is ignored.
- MODE and CLK_HALF are latched at the IDLE exit. Changes mid-transaction take effect on the next transaction.

Optional Feature:
- Macro: TLU_DUT_RESP_TIMEOUT_EN.
- Defined: a counter runs in WAIT_LOW.
  - If the synchronised trigger stays high for TIMEOUT_CYCLES cycles, set TIMEOUT_ERR (cleared only by RST) and go to DEAD.
  - No CLOCK pulses, no VALID strobe, TRIGGER_COUNT unchanged.
- Undefined: WAIT_LOW waits indefinitely. TIMEOUT_ERR is tied to 0 and no counter logic is present.

Test Plan:
- MODE 2, CLK_HALF=2, DEAD_TIME=0, TLU model serving ID 0x1234:
  - BUSY high 2 edges after the trigger rise; 16 CLOCK pulses, each 4 cycles long.
  - TRIGGER_ID=0x00001234, a single VALID strobe, COUNT=1, BUSY low 1 cycle after VALID.
- MODE 1, DEAD_TIME=10, trigger 5 cycles wide:
  - No CLOCK pulses; VALID with ID=0.
  - BUSY deasserts exactly 10 cycles after the LATCH cycle.
- MODE 0, three trigger pulses with 20-cycle spacing:
  - BUSY stays 0; VALID three times with IDs 0, 1, 2; COUNT=3.
- MODE 2, RST asserted after the 5th CLOCK pulse:
  - BUSY=0, CLOCK=0 and COUNT=0 on the next edge.
  - The following trigger with ID 0xBEEF reads 0xBEEF.
- Trigger held high across the end of a MODE 1 transaction:
  - No second transaction; a later low->high edge starts exactly one.
- With TLU_DUT_RESP_TIMEOUT_EN, TIMEOUT_CYCLES=100, MODE 2, trigger held high 300 cycles:
  - TIMEOUT_ERR=1 after 100 cycles in WAIT_LOW; no VALID, COUNT=0; BUSY released after DEAD_TIME.
  - Without the macro: BUSY stays high while the trigger is high, TIMEOUT_ERR=0.
